uart_load_rx: RTL

Serial byte receiver that sits directly upstream of the 8-bit tri-state counter. It turns a UART line on a dedicated input pin into the counter's parallel-load value and a one-cycle load strobe. This lets the load value be set over a single wire instead of the eight `uio_in` pins. Format is 8N1 (LSB first), with an optional even-parity bit.

---
 rtl/uart_load_rx.sv | 129 ++++++++++++
 1 files changed

// File: rtl/uart_load_rx.sv
// UART (8N1) receiver producing the tri-state counter's parallel-load byte and load strobe.
// Define UART_LOAD_PARITY_EN to add an even-parity bit between the data and the stop bit.
module uart_load_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] load_data,
  output logic       load_pulse,
  output logic       busy,
  output logic       frame_err,
  output logic       parity_err
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_LOAD_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t      state, next_state;
  logic        rx_meta, rx_s, rx_prev;
  logic [1:0]  fill;
  logic        armed;
  logic [15:0] cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        tick, start_edge;
  logic        go_start, false_start, do_shift, stop_smp, par_ok;
`ifdef UART_LOAD_PARITY_EN
  logic        par_bit, par_smp;
`endif

  assign tick       = (state == START) ? (cnt == HALF_LAST) : (cnt == BIT_LAST);
  assign start_edge = armed && rx_prev && !rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start_edge) next_state = START;
      START: if (tick) next_state = rx_s ? IDLE : DATA;
`ifdef UART_LOAD_PARITY_EN
      DATA:   if (tick && bit_cnt == 3'd7) next_state = PARITY;
      PARITY: if (tick) next_state = STOP;
`else
      DATA:  if (tick && bit_cnt == 3'd7) next_state = STOP;
`endif
      STOP:  if (tick) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    go_start    = (state == IDLE) && start_edge;
    false_start = (state == START) && tick && rx_s;
    do_shift    = (state == DATA) && tick;
    stop_smp    = (state == STOP) && tick;
`ifdef UART_LOAD_PARITY_EN
    par_smp     = (state == PARITY) && tick;
    par_ok      = ((^shift_reg) == par_bit);
`else
    par_ok      = 1'b1;
`endif
  end

  // fill tracks when the synchronizer holds real pin samples rather than its reset ones,
  // so a line held low through reset release can never look like an idle-high line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
      fill    <= 2'b00;
      armed   <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
      fill    <= {fill[0], 1'b1};
      if (fill[1] && rx_s) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      busy       <= 1'b0;
      load_pulse <= 1'b0;
      frame_err  <= 1'b0;
      load_data  <= '0;
    end else begin
      cnt <= (state == IDLE || tick) ? '0 : cnt + 16'd1;
      if (go_start)      bit_cnt <= '0;
      else if (do_shift) bit_cnt <= bit_cnt + 3'd1;
      if (do_shift) shift_reg <= {rx_s, shift_reg[7:1]};
      if (go_start)                      busy <= 1'b1;
      else if (false_start || stop_smp) busy <= 1'b0;
      load_pulse <= stop_smp && rx_s && par_ok;
      frame_err  <= stop_smp && !rx_s;
      if (stop_smp && rx_s && par_ok) load_data <= shift_reg;
    end
  end

`ifdef UART_LOAD_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (par_smp) par_bit <= rx_s;
      parity_err <= stop_smp && !par_ok;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
